fifo_stream_out: RTL and testbench

//  Read-side drain stage placed directly downstream of the FIFO controller and register file.

---
 rtl/fifo_stream_out_if.sv | 34 +++
 rtl/fifo_stream_out.sv | 84 ++++++++
 tb/tb_fifo_stream_out.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_out_if.sv
// Stream-out bundle: FIFO pop side plus valid/ready output stream.
// master = drain stage, slave = FIFO controller and consumer.
interface fifo_stream_out_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_WIDTH-1:0]  pop_count;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    input  out_ready,
    output fifo_rd,
    output out_data,
    output out_valid,
    output pop_count
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    output out_ready,
    input  fifo_rd,
    input  out_data,
    input  out_valid,
    input  pop_count
  );
endinterface

// File: rtl/fifo_stream_out.sv
// Read-side drain stage: pops the FIFO against a 2-credit budget and
// re-presents the returned words on a valid/ready stream via a 2-entry buffer.
module fifo_stream_out #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic                clk,
  input logic                reset,
  fifo_stream_out_if.master  bus
);

  logic [1:0]            occ_q;
  logic [1:0]            occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] head_d;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [DATA_WIDTH-1:0] tail_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  deq;
  logic                  cap;
  logic                  rd;
  logic [2:0]            lvl;

  assign deq = (occ_q != 2'd0) & bus.out_ready;
  assign cap = inflight_q;

  // deq implies occ>=1, so the level never underflows
  assign lvl = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, deq};
  assign rd  = ~reset & ~bus.fifo_empty & (lvl < 3'd2);

  assign bus.fifo_rd   = rd;
  assign bus.out_data  = head_q;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.pop_count = cnt_q;

  // buffer next state from dequeue / capture combination
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, deq};
    unique case ({deq, cap})
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = bus.fifo_rdata;
        end else begin
          head_d = tail_q;
          tail_d = bus.fifo_rdata;
        end
      end
      2'b10: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b01: begin
        if (occ_q == 2'd0) head_d = bus.fifo_rdata;
        else               tail_d = bus.fifo_rdata;
        occ_d = occ_q + 2'd1;
      end
      default: begin
      end
    endcase
  end

  // state registers; reset discards buffered and in-flight words
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= rd;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: FIFO controller model, word scoreboard,
// and per-scenario tasks.
module tb_fifo_stream_out;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       empty_q = 1'b1;
  logic [7:0] rdata_q = 8'h00;
  logic       out_ready = 1'b0;

  always #5 clk = ~clk;

  fifo_stream_out_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus16();
  fifo_stream_out_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  bus4();

  assign bus16.fifo_empty = empty_q;
  assign bus16.fifo_rdata = rdata_q;
  assign bus16.out_ready  = out_ready;
  assign bus4.fifo_empty  = empty_q;
  assign bus4.fifo_rdata  = rdata_q;
  assign bus4.out_ready   = out_ready;

  fifo_stream_out #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .bus(bus16)
  );

  fifo_stream_out #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  int unsigned popped = 0;
  int unsigned n_deq = 0;
  int          total = 0;
  int          bad = 0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [7:0]  pd = 8'h00;

  // FIFO controller: registered empty flag, registered read port
  always @(posedge clk) begin
    if (reset) begin
      fifo_q.delete();
      exp_q.delete();
      popped = 0;
      rdata_q <= 8'h00;
      empty_q <= 1'b1;
    end else begin
      if (bus16.fifo_rd && fifo_q.size() > 0) begin
        rdata_q <= fifo_q.pop_front();
        popped++;
      end
      empty_q <= (fifo_q.size() == 0);
    end
  end

  // stream monitor: order, credits, counters, hold-until-accepted
  always @(negedge clk) begin
    if (reset) begin
      n_deq = 0;
      pv = 1'b0;
    end else begin
      total++;
      if (n_deq > popped || popped - n_deq > 2) begin
        bad++;
        $display("FAIL outstanding: popped=%0d delivered=%0d need<=2",
                 popped, n_deq);
      end
      total++;
      if (bus16.pop_count !== n_deq[15:0]) begin
        bad++;
        $display("FAIL pop_count16: got=%0d exp=%0d",
                 bus16.pop_count, n_deq[15:0]);
      end
      total++;
      if (bus4.pop_count !== n_deq[3:0]) begin
        bad++;
        $display("FAIL pop_count4: got=%0d exp=%0d",
                 bus4.pop_count, n_deq[3:0]);
      end
      if (pv && !pr) begin
        total++;
        if (bus16.out_valid !== 1'b1 || bus16.out_data !== pd) begin
          bad++;
          $display("FAIL hold: valid=%b data=%h exp valid=1 data=%h",
                   bus16.out_valid, bus16.out_data, pd);
        end
      end
      if (bus16.out_valid === 1'b1 && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL order: got=%h exp=none", bus16.out_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus16.out_data !== e) begin
            bad++;
            $display("FAIL order: got=%h exp=%h", bus16.out_data, e);
          end
        end
        n_deq++;
      end
      pv = bus16.out_valid;
      pr = out_ready;
      pd = bus16.out_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    total++;
    if (bus16.out_valid !== 1'b0 || bus16.out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_out: valid=%b data=%h exp 0/00",
               bus16.out_valid, bus16.out_data);
    end
    total++;
    if (bus16.pop_count !== 16'd0 || bus4.pop_count !== 4'd0) begin
      bad++;
      $display("FAIL reset_cnt: got=%0d/%0d exp=0",
               bus16.pop_count, bus4.pop_count);
    end
    total++;
    if (bus16.fifo_rd !== 1'b0) begin
      bad++;
      $display("FAIL reset_rd: got=%b exp=0", bus16.fifo_rd);
    end
    cyc();
    reset = 1'b0;
    cyc();
    @(negedge clk);
    total++;
    if (bus16.fifo_rd !== 1'b0 || bus16.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_empty: rd=%b valid=%b exp 0/0",
               bus16.fifo_rd, bus16.out_valid);
    end
  endtask

  task automatic test_single();
    int nrd = 0;
    int nv = 0;
    int rd_at = -1;
    int v_at = -1;
    logic [7:0] vd = 8'h00;
    cyc();
    out_ready = 1'b1;
    push_word(8'hA5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus16.fifo_rd === 1'b1) begin nrd++; rd_at = i; end
      if (bus16.out_valid === 1'b1) begin nv++; v_at = i; vd = bus16.out_data; end
      cyc();
    end
    total++;
    if (nrd != 1 || nv != 1) begin
      bad++;
      $display("FAIL single_pulses: rd=%0d valid=%0d exp 1/1", nrd, nv);
    end
    total++;
    if (v_at - rd_at != 2) begin
      bad++;
      $display("FAIL single_latency: got=%0d exp=2", v_at - rd_at);
    end
    total++;
    if (vd !== 8'hA5) begin
      bad++;
      $display("FAIL single_data: got=%h exp=a5", vd);
    end
    @(negedge clk);
    total++;
    if (bus16.pop_count !== 16'd1) begin
      bad++;
      $display("FAIL single_cnt: got=%0d exp=1", bus16.pop_count);
    end
  endtask

  task automatic test_burst();
    int unsigned base;
    int nrd = 0;
    int nv = 0;
    int frd = -1;
    int lrd = -1;
    int fv = -1;
    int lv = -1;
    cyc();
    base = n_deq;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'(i));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus16.fifo_rd === 1'b1) begin
        nrd++;
        if (frd < 0) frd = i;
        lrd = i;
      end
      if (bus16.out_valid === 1'b1) begin
        nv++;
        if (fv < 0) fv = i;
        lv = i;
      end
      cyc();
    end
    total++;
    if (nrd != 8 || lrd - frd != 7) begin
      bad++;
      $display("FAIL burst_rd: pulses=%0d span=%0d exp 8/7", nrd, lrd - frd);
    end
    total++;
    if (nv != 8 || lv - fv != 7) begin
      bad++;
      $display("FAIL burst_out: cycles=%0d span=%0d exp 8/7", nv, lv - fv);
    end
    @(negedge clk);
    total++;
    if (bus16.pop_count !== 16'(base + 8) || bus16.fifo_rd !== 1'b0) begin
      bad++;
      $display("FAIL burst_end: cnt=%0d rd=%b exp %0d/0",
               bus16.pop_count, bus16.fifo_rd, base + 8);
    end
  endtask

  task automatic test_backpressure();
    int nrd = 0;
    int nd = 0;
    int fd = -1;
    int ld = -1;
    cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h10 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus16.fifo_rd === 1'b1) nrd++;
      cyc();
    end
    total++;
    if (nrd != 2) begin
      bad++;
      $display("FAIL bp_rd: pulses=%0d exp=2", nrd);
    end
    @(negedge clk);
    total++;
    if (bus16.out_valid !== 1'b1 || bus16.out_data !== 8'h10) begin
      bad++;
      $display("FAIL bp_head: valid=%b data=%h exp 1/10",
               bus16.out_valid, bus16.out_data);
    end
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus16.out_valid === 1'b1) begin
        nd++;
        if (fd < 0) fd = i;
        ld = i;
      end
      cyc();
    end
    total++;
    if (nd != 5 || ld - fd != 4 || fd != 0) begin
      bad++;
      $display("FAIL bp_drain: words=%0d span=%0d first=%0d exp 5/4/0",
               nd, ld - fd, fd);
    end
  endtask

  task automatic test_random();
    int unsigned base;
    int pushed = 0;
    cyc();
    base = n_deq;
    for (int c = 0; c < 6000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (pushed < 500) begin
        int k;
        k = $urandom_range(0, 2);
        for (int j = 0; j < k && pushed < 500; j++) begin
          push_word(8'($urandom_range(0, 255)));
          pushed++;
        end
      end
      cyc();
      if (n_deq - base >= 500) break;
    end
    total++;
    if (n_deq - base != 500 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL random_done: delivered=%0d left=%0d exp 500/0",
               n_deq - base, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h30 + 8'(i));
    repeat (6) cyc();
    @(negedge clk);
    total++;
    if (bus16.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rmid_fill: valid=%b exp=1", bus16.out_valid);
    end
    cyc();
    out_ready = 1'b1;
    cyc();
    reset = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (bus16.fifo_rd !== 1'b0) begin
      bad++;
      $display("FAIL rmid_rd_in_reset: got=%b exp=0", bus16.fifo_rd);
    end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus16.out_valid !== 1'b0 || bus16.out_data !== 8'h00 ||
        bus16.pop_count !== 16'd0 || bus16.fifo_rd !== 1'b0) begin
      bad++;
      $display("FAIL rmid_after: valid=%b data=%h cnt=%0d rd=%b exp 0/00/0/0",
               bus16.out_valid, bus16.out_data, bus16.pop_count, bus16.fifo_rd);
    end
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_word(8'hC0 + 8'(i));
    for (int c = 0; c < 30; c++) begin
      cyc();
      if (n_deq >= 6) break;
    end
    total++;
    if (n_deq != 6 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rmid_fresh: delivered=%0d left=%0d exp 6/0",
               n_deq, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    logic seen = 1'b0;
    do_reset();
    prev = 4'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word(8'h60 + 8'(i));
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (prev == 4'd15 && bus4.pop_count === 4'd0) seen = 1'b1;
      prev = bus4.pop_count;
      cyc();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wrap_seen: got=0 exp=1");
    end
    @(negedge clk);
    total++;
    if (bus4.pop_count !== 4'd1 || bus16.pop_count !== 16'd17) begin
      bad++;
      $display("FAIL wrap_end: cnt4=%0d cnt16=%0d exp 1/17",
               bus4.pop_count, bus16.pop_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
